sevenseg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an NDIG-digit common-anode seven-segment display.
- All digits share one 4-bit seven-segment decoder. This block selects one digit at a time, drives its nibble to the decoder and enables that digit's anode.
- Incoming display values are double-buffered so a frame never shows a mix of old and new digits.
- Includes optional leading-zero blanking, an inter-digit ghost-suppression gap and a run enable.

---
 rtl/sevenseg_scan_ctrl.sv | 117 +++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller for an NDIG-digit common-anode display sharing one BCD decoder.
// All outputs are registered and double-buffered updates land only on the frame boundary.
module sevenseg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DWELL = 50000,
    parameter int GAP   = 500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic              blank_lz,
    output logic [3:0]        digit_data,
    output logic [NDIG-1:0]   anodes,
    output logic              frame_start
);

    localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NDIG);

    localparam logic [IW-1:0] LAST      = IW'(NDIG - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(GAP - 1);
    localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);

    typedef enum logic {S_GAP, S_DWELL} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [4*NDIG-1:0] active, active_nxt;
    logic [4*NDIG-1:0] pending;
    logic              pend_valid;
    logic              boundary;

    // Nibble shown for digit k; digit 0 always shows so a zero value reads "0".
    function automatic logic [3:0] eff(input logic [4*NDIG-1:0] act,
                                       input logic [IW-1:0]     k,
                                       input logic              blz);
        logic       upper_zero;
        logic [3:0] nib;
        upper_zero = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (i >= int'(k) && act[4*i +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
        nib = act[4*int'(k) +: 4];
        if (blz && k != '0 && upper_zero)
            nib = 4'hF;
        return nib;
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        boundary  = 1'b0;
        if (en) begin
            if (state == S_GAP) begin
                if (cnt == GAP_END) begin
                    state_nxt = S_DWELL;
                    cnt_nxt   = '0;
                    idx_nxt   = (idx == LAST) ? '0 : idx + IW'(1);
                    boundary  = (idx == LAST);
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end else begin
                if (cnt == DWELL_END) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
        end
        active_nxt = (boundary && pend_valid) ? pending : active;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_GAP;
            idx         <= LAST;
            cnt         <= '0;
            active      <= '0;
            pending     <= '0;
            pend_valid  <= 1'b0;
            anodes      <= '1;
            digit_data  <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            active <= active_nxt;

            // A load coinciding with the boundary stays pending for the next frame.
            if (load) begin
                pending    <= value;
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end

            if (en && state_nxt == S_DWELL) begin
                anodes     <= ~(NDIG'(1) << idx_nxt);
                digit_data <= eff(active_nxt, idx_nxt, blank_lz);
            end else begin
                anodes     <= '1;
                digit_data <= 4'hF;
            end
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with NDIG=4, DWELL=4, GAP=1 (20-cycle frame).
module tb_sevenseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  digit_data;
    logic [3:0]  anodes;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    sevenseg_scan_ctrl #(.NDIG(4), .DWELL(4), .GAP(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .load        (load),
        .value       (value),
        .blank_lz    (blank_lz),
        .digit_data  (digit_data),
        .anodes      (anodes),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [3:0] an, input logic [3:0] dd, input logic fs);
        chk({tag, ".anodes"}, 32'(anodes), 32'(an));
        chk({tag, ".data"}, 32'(digit_data), 32'(dd));
        chk({tag, ".fs"}, 32'(frame_start), 32'(fs));
    endtask

    task automatic see(input string tag, input logic [3:0] an, input logic [3:0] dd, input logic fs);
        tick();
        check_now(tag, an, dd, fs);
    endtask

    task automatic gap_see(input string tag);
        see({tag, ".gap"}, 4'hF, 4'hF, 1'b0);
    endtask

    task automatic dwell_see(input string tag, input int k, input logic [3:0] d, input logic fs);
        logic [3:0] an;
        an = ~(4'b0001 << k);
        see($sformatf("%s.d%0d", tag, k), an, d, fs);
    endtask

    task automatic dig(input string tag, input int k, input logic [3:0] d);
        for (int c = 0; c < 4; c++)
            dwell_see(tag, k, d, (k == 0) && (c == 0));
        gap_see(tag);
    endtask

    // shown: expected display nibble per digit; optional load pulse in digit 1's second cycle.
    task automatic frame(input string tag, input logic [15:0] shown,
                         input logic ld, input logic [15:0] ldval);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (ld && k == 1 && c == 1) begin
                    load  = 1'b1;
                    value = ldval;
                end
                dwell_see(tag, k, shown[4*k +: 4], (k == 0) && (c == 0));
                load = 1'b0;
            end
            gap_see(tag);
        end
    endtask

    initial begin
        // Reset state and first frames
        tick();
        tick();
        check_now("rst", 4'hF, 4'hF, 1'b0);
        reset = 1'b0;
        check_now("t1.first_gap", 4'hF, 4'hF, 1'b0);
        frame("t1a", 16'h0000, 1'b0, 16'h0000);
        frame("t1b", 16'h0000, 1'b0, 16'h0000);

        // Tear-free update: load lands only at the next frame
        frame("t2a", 16'h0000, 1'b1, 16'h1234);
        frame("t2b", 16'h1234, 1'b1, 16'h0070);

        // Leading-zero blanking
        blank_lz = 1'b1;
        frame("t4a", 16'hFF70, 1'b0, 16'h0000);
        blank_lz = 1'b0;
        frame("t4b", 16'h0070, 1'b1, 16'h0000);
        blank_lz = 1'b1;
        frame("t4c", 16'hFFF0, 1'b1, 16'h1234);

        // Collision: load on the boundary cycle while 1234 is pending
        blank_lz = 1'b0;
        load  = 1'b1;
        value = 16'h5678;
        frame("t3a", 16'h1234, 1'b0, 16'h0000);
        frame("t3b", 16'h5678, 1'b0, 16'h0000);

        // Enable freeze during digit 2
        dig("t5", 0, 4'h8);
        dig("t5", 1, 4'h7);
        dwell_see("t5", 2, 4'h6, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 7; i++)
            see("t5.frozen", 4'hF, 4'hF, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 3; i++)
            dwell_see("t5.resume", 2, 4'h6, 1'b0);
        gap_see("t5");
        dwell_see("t5", 3, 4'h5, 1'b0);
        dwell_see("t5", 3, 4'h5, 1'b0);
        load  = 1'b1;
        value = 16'h9999;
        dwell_see("t5", 3, 4'h5, 1'b0);
        load = 1'b0;

        // Asynchronous reset during digit 3 dwell, with a value pending
        reset = 1'b1;
        #1;
        check_now("t6.async", 4'hF, 4'hF, 1'b0);
        see("t6.hold", 4'hF, 4'hF, 1'b0);
        see("t6.hold", 4'hF, 4'hF, 1'b0);
        reset = 1'b0;
        check_now("t6.first_gap", 4'hF, 4'hF, 1'b0);
        frame("t6a", 16'h0000, 1'b0, 16'h0000);
        frame("t6b", 16'h0000, 1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
